pool_max_stream: RTL and testbench



---
 rtl/pool_max_stream_if.sv | 35 +++
 rtl/pool_max_stream.sv | 112 +++++++++++
 tb/tb_pool_max_stream.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_max_stream_if.sv
// Valid/ready stream bundle for pool_max_stream (input side and registered result side).
// out_idx exists only when POOL_ARGMAX_EN is defined.
interface pool_max_stream_if #(
   parameter int WIDTH = 9,
   parameter int LANES = 4,
   parameter int WIN   = 4
);
   localparam int IW = (WIN > 1) ? $clog2(WIN) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*WIDTH-1:0]   in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*WIDTH-1:0]   out_data;
`ifdef POOL_ARGMAX_EN
   logic [LANES*IW-1:0]      out_idx;
`endif

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
`ifdef POOL_ARGMAX_EN
      , input out_idx
`endif
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
`ifdef POOL_ARGMAX_EN
      , output out_idx
`endif
   );
endinterface

// File: rtl/pool_max_stream.sv
// Streaming multi-lane signed max-pooling over WIN samples per lane, one-deep registered output.
// Optional POOL_ARGMAX_EN adds per-lane argmax tracking and the out_idx result.
module pool_max_stream #(
   parameter int WIDTH = 9,
   parameter int LANES = 4,
   parameter int WIN   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   pool_max_stream_if.slave s_if
);
   localparam int            IW   = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIN - 1);

   logic [IW-1:0]           r_cnt;
   logic                    r_out_valid;
   logic signed [WIDTH-1:0] r_acc      [LANES];
   logic signed [WIDTH-1:0] r_out_data [LANES];
   logic signed [WIDTH-1:0] w_sample   [LANES];
   logic signed [WIDTH-1:0] w_max      [LANES];
   logic                    w_accept;
   logic                    w_take;
   logic                    w_first;
   logic                    w_close;

`ifdef POOL_ARGMAX_EN
   logic [IW-1:0] r_idx     [LANES];
   logic [IW-1:0] r_out_idx [LANES];
   logic [IW-1:0] w_max_idx [LANES];
`endif

   assign s_if.in_ready  = !r_out_valid || s_if.out_ready;
   assign s_if.out_valid = r_out_valid;
   assign w_accept       = s_if.in_valid && s_if.in_ready;
   // A sample accepted under flush is dropped, so it neither accumulates nor closes.
   assign w_take         = w_accept && !flush;
   assign w_first        = (r_cnt == '0);
   assign w_close        = w_take && (r_cnt == LAST);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic w_gt;
         assign w_sample[gi] = s_if.in_data[gi*WIDTH +: WIDTH];
         // Strict signed compare keeps the earlier value on ties.
         assign w_gt         = w_sample[gi] > r_acc[gi];
         assign w_max[gi]    = (w_first || w_gt) ? w_sample[gi] : r_acc[gi];
         assign s_if.out_data[gi*WIDTH +: WIDTH] = r_out_data[gi];
`ifdef POOL_ARGMAX_EN
         assign w_max_idx[gi] = w_first ? '0 : (w_gt ? r_cnt : r_idx[gi]);
         assign s_if.out_idx[gi*IW +: IW] = r_out_idx[gi];
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (flush) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
         end
         // A window closing in the handshake cycle keeps the output valid with new data.
         if (w_close) begin
            r_out_valid <= 1'b1;
         end else if (r_out_valid && s_if.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            r_acc[i]      <= '0;
            r_out_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (w_take) begin
               r_acc[i] <= w_max[i];
            end
            if (w_close) begin
               r_out_data[i] <= w_max[i];
            end
         end
      end
   end

`ifdef POOL_ARGMAX_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            r_idx[i]     <= '0;
            r_out_idx[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (w_take) begin
               r_idx[i] <= w_max_idx[i];
            end
            if (w_close) begin
               r_out_idx[i] <= w_max_idx[i];
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_pool_max_stream.sv
// Scoreboard bench for pool_max_stream: a lane-max model queues expected results, a monitor logs handshakes.
module tb_pool_max_stream;
   localparam int WIDTH = 9;
   localparam int LANES = 4;
   localparam int WIN   = 4;
   localparam int IW    = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int DW    = LANES * WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   pool_max_stream_if #(.WIDTH(WIDTH), .LANES(LANES), .WIN(WIN)) dut_if ();

   pool_max_stream #(.WIDTH(WIDTH), .LANES(LANES), .WIN(WIN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .s_if  (dut_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: a result observed valid&&ready at negedge transfers on the following posedge.
   logic [DW-1:0] obs_d [64];
   int            obs_t [64];
   int            obs_n = 0;
`ifdef POOL_ARGMAX_EN
   logic [LANES*IW-1:0] obs_i [64];
`endif
   always @(negedge clk) begin
      if (rst_n && dut_if.out_valid && dut_if.out_ready && obs_n < 64) begin
         obs_d[obs_n] = dut_if.out_data;
`ifdef POOL_ARGMAX_EN
         obs_i[obs_n] = dut_if.out_idx;
`endif
         obs_t[obs_n] = cyc;
         obs_n = obs_n + 1;
      end
   end

   // Reference model and scoreboard
   logic signed [WIDTH-1:0] m_acc [LANES];
   int                      m_idx [LANES];
   int                      m_cnt = 0;
   int                      rd_ptr = 0;
   logic [DW-1:0]           exp_q [$];
`ifdef POOL_ARGMAX_EN
   logic [LANES*IW-1:0]     exp_i_q [$];
`endif

   function automatic logic [DW-1:0] mk(input int a, input int b, input int c, input int d);
      logic [DW-1:0] v;
      v[0*WIDTH +: WIDTH] = WIDTH'(a);
      v[1*WIDTH +: WIDTH] = WIDTH'(b);
      v[2*WIDTH +: WIDTH] = WIDTH'(c);
      v[3*WIDTH +: WIDTH] = WIDTH'(d);
      return v;
   endfunction

   task automatic model_accept(input logic [DW-1:0] vec, input logic fl);
      logic signed [WIDTH-1:0] s;
      logic [DW-1:0]           d;
      logic [LANES*IW-1:0]     ix;
      if (fl) begin
         m_cnt = 0;
         return;
      end
      for (int l = 0; l < LANES; l++) begin
         s = vec[l*WIDTH +: WIDTH];
         if (m_cnt == 0 || s > m_acc[l]) begin
            m_acc[l] = s;
            m_idx[l] = m_cnt;
         end
      end
      if (m_cnt == WIN - 1) begin
         for (int l = 0; l < LANES; l++) begin
            d[l*WIDTH +: WIDTH] = m_acc[l];
            ix[l*IW +: IW]      = IW'(m_idx[l]);
         end
         exp_q.push_back(d);
`ifdef POOL_ARGMAX_EN
         exp_i_q.push_back(ix);
`endif
         m_cnt = 0;
      end else begin
         m_cnt = m_cnt + 1;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one vector until accepted; returns 1 time unit after the accepting edge.
   task automatic send(input logic [DW-1:0] vec, input logic fl);
      int waited;
      waited = 0;
      dut_if.in_valid = 1'b1;
      dut_if.in_data  = vec;
      flush           = fl;
      @(negedge clk);
      while (!dut_if.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!dut_if.in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout in_ready=%0b required=1", dut_if.in_ready);
      end else begin
         model_accept(vec, fl);
      end
      @(posedge clk);
      #1;
      dut_if.in_valid = 1'b0;
      flush           = 1'b0;
   endtask

   task automatic test_reset();
      dut_if.in_valid  = 1'b0;
      dut_if.in_data   = '0;
      dut_if.out_ready = 1'b1;
      rst_n = 1'b0;
      step(3);
      n_tests++;
      if (dut_if.out_valid !== 1'b0 || dut_if.out_data !== '0 || dut_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hold out_valid=%0b out_data=%h in_ready=%0b required 0/0/1",
                  dut_if.out_valid, dut_if.out_data, dut_if.in_ready);
      end
      rst_n = 1'b1;
      step(5);
      n_tests++;
      if (dut_if.out_valid !== 1'b0 || obs_n !== 0 || dut_if.in_ready !== 1'b1 || dut_if.out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_idle out_valid=%0b results=%0d in_ready=%0b required 0/0/1",
                  dut_if.out_valid, obs_n, dut_if.in_ready);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_basic();
      int                  waited;
      logic [DW-1:0]       e;
`ifdef POOL_ARGMAX_EN
      logic [LANES*IW-1:0] ei;
      logic [LANES*IW-1:0] ri;
`endif
      dut_if.out_ready = 1'b1;
      send(mk(5, -256, 255, 7), 1'b0);
      send(mk(-3, -1, -256, 7), 1'b0);
      send(mk(17, -128, 0, 7), 1'b0);
      n_tests++;
      if (dut_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_early out_valid=%0b required=0", dut_if.out_valid);
      end
      send(mk(2, -2, 0, 7), 1'b0);
      n_tests++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_data !== mk(17, -1, 255, 7)) begin
         n_fail++;
         $display("FAIL basic_result out_valid=%0b out_data=%h required 1/%h",
                  dut_if.out_valid, dut_if.out_data, mk(17, -1, 255, 7));
      end
`ifdef POOL_ARGMAX_EN
      ri = '0;
      ri[0*IW +: IW] = IW'(2);
      ri[1*IW +: IW] = IW'(1);
      n_tests++;
      if (dut_if.out_idx !== ri) begin
         n_fail++;
         $display("FAIL basic_idx got=%h required=%h", dut_if.out_idx, ri);
      end
`endif
      step(2);
      waited = 0;
      while (obs_n - rd_ptr < exp_q.size() && waited < 100) begin step(1); waited++; end
      n_tests++;
      if (obs_n - rd_ptr != exp_q.size()) begin
         n_fail++;
         $display("FAIL basic_count got=%0d required=%0d", obs_n - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < obs_n) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_d[rd_ptr] !== e) begin
            n_fail++;
            $display("FAIL basic_sb got=%h required=%h", obs_d[rd_ptr], e);
         end
`ifdef POOL_ARGMAX_EN
         ei = exp_i_q.pop_front();
         n_tests++;
         if (obs_i[rd_ptr] !== ei) begin
            n_fail++;
            $display("FAIL basic_sb_idx got=%h required=%h", obs_i[rd_ptr], ei);
         end
`endif
         rd_ptr++;
      end
      exp_q.delete();
`ifdef POOL_ARGMAX_EN
      exp_i_q.delete();
`endif
      rd_ptr = obs_n;
      $display("[TB] test_basic done");
   endtask

   task automatic test_backpressure();
      int                  waited;
      logic [DW-1:0]       e;
      logic [DW-1:0]       w1;
`ifdef POOL_ARGMAX_EN
      logic [LANES*IW-1:0] ei;
`endif
      dut_if.out_ready = 1'b1;
      send(mk(10, -10, 3, 0), 1'b0);
      send(mk(-4, 20, 3, 1), 1'b0);
      send(mk(8, -30, -3, 2), 1'b0);
      send(mk(11, 5, 2, -1), 1'b0);
      w1 = mk(11, 20, 3, 2);
      dut_if.out_ready = 1'b0;
      dut_if.in_valid  = 1'b1;
      dut_if.in_data   = mk(1, 1, 1, 1);
      for (int k = 0; k < 3; k++) begin
         step(1);
         n_tests++;
         if (dut_if.in_ready !== 1'b0 || dut_if.out_valid !== 1'b1 || dut_if.out_data !== w1) begin
            n_fail++;
            $display("FAIL bp_hold in_ready=%0b out_valid=%0b out_data=%h required 0/1/%h",
                     dut_if.in_ready, dut_if.out_valid, dut_if.out_data, w1);
         end
      end
      dut_if.out_ready = 1'b1;
      send(mk(1, 1, 1, 1), 1'b0);
      send(mk(-1, 6, 0, 0), 1'b0);
      send(mk(3, 2, 0, 9), 1'b0);
      send(mk(0, 0, -7, 0), 1'b0);
      n_tests++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_data !== mk(3, 6, 1, 9)) begin
         n_fail++;
         $display("FAIL bp_second out_valid=%0b out_data=%h required 1/%h",
                  dut_if.out_valid, dut_if.out_data, mk(3, 6, 1, 9));
      end
      step(2);
      waited = 0;
      while (obs_n - rd_ptr < exp_q.size() && waited < 100) begin step(1); waited++; end
      n_tests++;
      if (obs_n - rd_ptr != exp_q.size()) begin
         n_fail++;
         $display("FAIL bp_count got=%0d required=%0d", obs_n - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < obs_n) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_d[rd_ptr] !== e) begin
            n_fail++;
            $display("FAIL bp_sb got=%h required=%h", obs_d[rd_ptr], e);
         end
`ifdef POOL_ARGMAX_EN
         ei = exp_i_q.pop_front();
         n_tests++;
         if (obs_i[rd_ptr] !== ei) begin
            n_fail++;
            $display("FAIL bp_sb_idx got=%h required=%h", obs_i[rd_ptr], ei);
         end
`endif
         rd_ptr++;
      end
      exp_q.delete();
`ifdef POOL_ARGMAX_EN
      exp_i_q.delete();
`endif
      rd_ptr = obs_n;
      $display("[TB] test_backpressure done");
   endtask

   task automatic test_back_to_back();
      int                  waited;
      int                  t0;
      int                  first;
      logic [DW-1:0]       e;
      logic [DW-1:0]       v;
`ifdef POOL_ARGMAX_EN
      logic [LANES*IW-1:0] ei;
`endif
      dut_if.out_ready = 1'b1;
      t0    = cyc;
      first = obs_n;
      for (int k = 0; k < 64; k++) begin
         v = DW'({$urandom(), $urandom()});
         send(v, 1'b0);
      end
      n_tests++;
      if (cyc - t0 != 64) begin
         n_fail++;
         $display("FAIL b2b_cycles got=%0d required=64", cyc - t0);
      end
      step(2);
      for (int k = first + 1; k < obs_n; k++) begin
         n_tests++;
         if (obs_t[k] - obs_t[k-1] != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing result=%0d gap=%0d required=4", k - first, obs_t[k] - obs_t[k-1]);
         end
      end
      waited = 0;
      while (obs_n - rd_ptr < exp_q.size() && waited < 100) begin step(1); waited++; end
      n_tests++;
      if (obs_n - rd_ptr != 16 || exp_q.size() != 16) begin
         n_fail++;
         $display("FAIL b2b_count got=%0d model=%0d required=16", obs_n - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < obs_n) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_d[rd_ptr] !== e) begin
            n_fail++;
            $display("FAIL b2b_sb got=%h required=%h", obs_d[rd_ptr], e);
         end
`ifdef POOL_ARGMAX_EN
         ei = exp_i_q.pop_front();
         n_tests++;
         if (obs_i[rd_ptr] !== ei) begin
            n_fail++;
            $display("FAIL b2b_sb_idx got=%h required=%h", obs_i[rd_ptr], ei);
         end
`endif
         rd_ptr++;
      end
      exp_q.delete();
`ifdef POOL_ARGMAX_EN
      exp_i_q.delete();
`endif
      rd_ptr = obs_n;
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_flush();
      int                  waited;
      logic [DW-1:0]       e;
`ifdef POOL_ARGMAX_EN
      logic [LANES*IW-1:0] ei;
`endif
      dut_if.out_ready = 1'b1;
      send(mk(100, 1, 1, 1), 1'b0);
      send(mk(50, 2, 2, 2), 1'b0);
      send(mk(120, 90, 90, 90), 1'b1);
      send(mk(1, -5, 0, -100), 1'b0);
      send(mk(2, -6, 0, -100), 1'b0);
      send(mk(3, -7, 0, -100), 1'b0);
      send(mk(4, -8, 0, -99), 1'b0);
      n_tests++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_data !== mk(4, -5, 0, -99)) begin
         n_fail++;
         $display("FAIL flush_drop out_valid=%0b out_data=%h required 1/%h",
                  dut_if.out_valid, dut_if.out_data, mk(4, -5, 0, -99));
      end
      step(2);
      dut_if.out_ready = 1'b0;
      send(mk(9, -9, 0, 1), 1'b0);
      send(mk(-9, 9, 0, 2), 1'b0);
      send(mk(0, 0, 5, 3), 1'b0);
      send(mk(1, 1, -5, 4), 1'b0);
      flush = 1'b1;
      model_accept('0, 1'b1);
      step(1);
      flush = 1'b0;
      step(2);
      n_tests++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_data !== mk(9, 9, 5, 4)) begin
         n_fail++;
         $display("FAIL flush_pending out_valid=%0b out_data=%h required 1/%h",
                  dut_if.out_valid, dut_if.out_data, mk(9, 9, 5, 4));
      end
      dut_if.out_ready = 1'b1;
      step(2);
      waited = 0;
      while (obs_n - rd_ptr < exp_q.size() && waited < 100) begin step(1); waited++; end
      n_tests++;
      if (obs_n - rd_ptr != exp_q.size()) begin
         n_fail++;
         $display("FAIL flush_count got=%0d required=%0d", obs_n - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < obs_n) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_d[rd_ptr] !== e) begin
            n_fail++;
            $display("FAIL flush_sb got=%h required=%h", obs_d[rd_ptr], e);
         end
`ifdef POOL_ARGMAX_EN
         ei = exp_i_q.pop_front();
         n_tests++;
         if (obs_i[rd_ptr] !== ei) begin
            n_fail++;
            $display("FAIL flush_sb_idx got=%h required=%h", obs_i[rd_ptr], ei);
         end
`endif
         rd_ptr++;
      end
      exp_q.delete();
`ifdef POOL_ARGMAX_EN
      exp_i_q.delete();
`endif
      rd_ptr = obs_n;
      $display("[TB] test_flush done");
   endtask

   task automatic test_async_reset();
      int                  waited;
      logic [DW-1:0]       e;
`ifdef POOL_ARGMAX_EN
      logic [LANES*IW-1:0] ei;
`endif
      dut_if.out_ready = 1'b1;
      send(mk(200, 200, 200, 200), 1'b0);
      send(mk(201, 150, 100, 50), 1'b0);
      send(mk(202, 199, 90, 60), 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (dut_if.out_valid !== 1'b0 || dut_if.out_data !== '0 || dut_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_clear out_valid=%0b out_data=%h in_ready=%0b required 0/0/1",
                  dut_if.out_valid, dut_if.out_data, dut_if.in_ready);
      end
      m_cnt = 0;
      exp_q.delete();
`ifdef POOL_ARGMAX_EN
      exp_i_q.delete();
`endif
      rst_n = 1'b1;
      step(1);
      send(mk(1, -1, -2, 3), 1'b0);
      send(mk(2, -2, -3, 3), 1'b0);
      send(mk(3, -3, -4, 3), 1'b0);
      send(mk(4, -4, -5, 3), 1'b0);
      n_tests++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_data !== mk(4, -1, -2, 3)) begin
         n_fail++;
         $display("FAIL areset_fresh out_valid=%0b out_data=%h required 1/%h",
                  dut_if.out_valid, dut_if.out_data, mk(4, -1, -2, 3));
      end
      step(2);
      waited = 0;
      while (obs_n - rd_ptr < exp_q.size() && waited < 100) begin step(1); waited++; end
      n_tests++;
      if (obs_n - rd_ptr != exp_q.size()) begin
         n_fail++;
         $display("FAIL areset_count got=%0d required=%0d", obs_n - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < obs_n) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_d[rd_ptr] !== e) begin
            n_fail++;
            $display("FAIL areset_sb got=%h required=%h", obs_d[rd_ptr], e);
         end
`ifdef POOL_ARGMAX_EN
         ei = exp_i_q.pop_front();
         n_tests++;
         if (obs_i[rd_ptr] !== ei) begin
            n_fail++;
            $display("FAIL areset_sb_idx got=%h required=%h", obs_i[rd_ptr], ei);
         end
`endif
         rd_ptr++;
      end
      exp_q.delete();
`ifdef POOL_ARGMAX_EN
      exp_i_q.delete();
`endif
      rd_ptr = obs_n;
      $display("[TB] test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
